// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI4-Stream test packet transmitter.
// Sends a latched number of fixed-length packets. Byte k of each packet
// carries k[7:0]. tuser uses the NetFPGA metadata layout.
module axis_pkt_gen #(
    parameter int          C_AXIS_DATA_WIDTH = 32,
    parameter int          C_AXIS_USER_WIDTH = 128,
    parameter logic [7:0]  SRC_PORT          = 8'h01
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [15:0]                    pkt_len,
    input  logic [15:0]                    pkt_count,
    input  logic [7:0]                     dst_port,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    tx_pkts,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                           m_axis_tlast,
    output logic [C_AXIS_USER_WIDTH-1:0]   m_axis_tuser
);

    localparam int          B      = C_AXIS_DATA_WIDTH / 8;
    localparam logic [16:0] B_WIDE = 17'(B);
    localparam logic [15:0] B_STEP = 16'(B);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t      state_reg,   state_next;
    logic [15:0] len_reg,     len_next;
    logic [15:0] count_reg,   count_next;
    logic [7:0]  dst_reg,     dst_next;
    logic [15:0] offset_reg,  offset_next;
    logic [15:0] pkt_idx_reg, pkt_idx_next;
    logic [31:0] tx_pkts_reg, tx_pkts_next;

    logic                           sending;
    logic                           handshake;
    logic                           last_beat;
    logic [16:0]                    beat_end;
    logic [B-1:0]                   lane_en;
    logic [C_AXIS_USER_WIDTH-1:0]   tuser_word;

    assign sending   = (state_reg == ST_SEND);
    assign handshake = sending & m_axis_tready;
    // 17-bit sum so a beat straddling offset 65535 cannot alias
    assign beat_end  = {1'b0, offset_reg} + B_WIDE;
    assign last_beat = (beat_end >= {1'b0, len_reg});

    // Per-lane byte value and enable; lanes beyond pkt_len are zeroed
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_lane
            logic [16:0] lane_off;
            assign lane_off    = {1'b0, offset_reg} + 17'(gi);
            assign lane_en[gi] = sending && (lane_off < {1'b0, len_reg});
            assign m_axis_tdata[8*gi +: 8] = lane_en[gi] ? lane_off[7:0] : 8'h00;
        end
    endgenerate

    // Metadata word, driven only while a packet is being sent
    always_comb begin
        tuser_word = '0;
        if (sending) begin
            tuser_word[15:0]  = len_reg;
            tuser_word[23:16] = SRC_PORT;
            tuser_word[31:24] = dst_reg;
        end
    end

    assign m_axis_tstrb  = lane_en;
    assign m_axis_tuser  = tuser_word;
    assign m_axis_tvalid = sending;
    assign m_axis_tlast  = sending & last_beat;
    assign busy          = sending;
    assign done          = (state_reg == ST_DONE);
    assign tx_pkts       = tx_pkts_reg;

    // Next-state and datapath update
    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        count_next   = count_reg;
        dst_next     = dst_reg;
        offset_next  = offset_reg;
        pkt_idx_next = pkt_idx_reg;
        tx_pkts_next = tx_pkts_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next     = pkt_len;
                    count_next   = pkt_count;
                    dst_next     = dst_port;
                    offset_next  = 16'd0;
                    pkt_idx_next = 16'd0;
                    if ((pkt_len != 16'd0) && (pkt_count != 16'd0)) begin
                        state_next = ST_SEND;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (last_beat) begin
                        offset_next  = 16'd0;
                        tx_pkts_next = tx_pkts_reg + 32'd1;
                        if (pkt_idx_reg == count_reg - 16'd1) begin
                            state_next = ST_DONE;
                        end else begin
                            pkt_idx_next = pkt_idx_reg + 16'd1;
                        end
                    end else begin
                        offset_next = offset_reg + B_STEP;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            len_reg     <= 16'd0;
            count_reg   <= 16'd0;
            dst_reg     <= 8'd0;
            offset_reg  <= 16'd0;
            pkt_idx_reg <= 16'd0;
            tx_pkts_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            count_reg   <= count_next;
            dst_reg     <= dst_next;
            offset_reg  <= offset_next;
            pkt_idx_reg <= pkt_idx_next;
            tx_pkts_reg <= tx_pkts_next;
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: table vectors, hand sequences and randomized runs
// against a packet-level reference model for axis_pkt_gen (32-bit bus).
module tb_axis_pkt_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  pkt_len;
    logic [15:0]  pkt_count;
    logic [7:0]   dst_port;
    logic         busy;
    logic         done;
    logic [31:0]  tx_pkts;
    logic         tvalid;
    logic         tready;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic [127:0] tuser;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_tx = 32'd0;

    axis_pkt_gen #(
        .C_AXIS_DATA_WIDTH(32),
        .C_AXIS_USER_WIDTH(128),
        .SRC_PORT(8'h01)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pkt_len(pkt_len),
        .pkt_count(pkt_count),
        .dst_port(dst_port),
        .busy(busy),
        .done(done),
        .tx_pkts(tx_pkts),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tdata(tdata),
        .m_axis_tstrb(tstrb),
        .m_axis_tlast(tlast),
        .m_axis_tuser(tuser)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          beat;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    vec_t  vt[10];
    beat_t exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] user_of(input int len, input logic [7:0] dst);
        logic [127:0] u;
        u = '0;
        u[15:0]  = 16'(len);
        u[23:16] = 8'h01;
        u[31:24] = dst;
        return u;
    endfunction

    // Reference: expected beat list from packet length and count
    task automatic build_model(input int len, input int count);
        exp_q.delete();
        if (len == 0 || count == 0) return;
        for (int p = 0; p < count; p++) begin
            int nb;
            nb = (len + 3) / 4;
            for (int b = 0; b < nb; b++) begin
                beat_t bt;
                bt.d = '0;
                bt.s = '0;
                for (int i = 0; i < 4; i++) begin
                    int k;
                    k = b * 4 + i;
                    if (k < len) begin
                        bt.d[8*i +: 8] = 8'(k % 256);
                        bt.s[i] = 1'b1;
                    end
                end
                bt.l = (b == nb - 1);
                exp_q.push_back(bt);
            end
        end
    endtask

    // Full run with random tready, checked beat by beat against the model
    task automatic run_pkts(input int len, input int count, input logic [7:0] dst, input bit inject);
        bit          seen_done;
        bit          prev_stall;
        int          done_cyc;
        logic [31:0] pd;
        logic [3:0]  ps;
        logic        pl;
        logic [127:0] pu;
        build_model(len, count);
        pkt_len   = 16'(len);
        pkt_count = 16'(count);
        dst_port  = dst;
        start     = 1'b1;
        tick();
        start      = 1'b0;
        seen_done  = 1'b0;
        prev_stall = 1'b0;
        done_cyc   = -1;
        pd = '0; ps = '0; pl = 1'b0; pu = '0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (inject && cyc == 2) begin
                start     = 1'b1;
                pkt_len   = 16'd33;
                pkt_count = 16'd7;
                dst_port  = ~dst;
            end else begin
                start = 1'b0;
            end
            tready = 1'($urandom_range(0, 3) != 0);
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                check("done_busy", busy, 1'b0);
                check("done_tvalid", tvalid, 1'b0);
                break;
            end
            if (prev_stall) begin
                check("stall_tvalid", tvalid, 1'b1);
                check("stall_tdata", tdata, pd);
                check("stall_tstrb", tstrb, ps);
                check("stall_tlast", tlast, pl);
                check("stall_tuser", tuser, pu);
            end
            if (tvalid) begin
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1'b1, 1'b0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_tdata", tdata, e.d);
                        check("beat_tstrb", tstrb, e.s);
                        check("beat_tlast", tlast, e.l);
                        check("beat_tuser", tuser, user_of(len, dst));
                        if (e.l) exp_tx = exp_tx + 32'd1;
                    end
                end
                prev_stall = !tready;
                pd = tdata; ps = tstrb; pl = tlast; pu = tuser;
            end else begin
                prev_stall = 1'b0;
            end
            tick();
        end
        start  = 1'b0;
        tready = 1'b1;
        check("run_done_seen", seen_done, 1'b1);
        check("run_beats_left", exp_q.size(), 0);
        check("run_tx_pkts", tx_pkts, exp_tx);
        if (len == 0 || count == 0) check("degen_done_cycle", done_cyc, 1);
        $display("run len=%0d count=%0d inject=%0d done_cycle=%0d tx_pkts=%0d",
                 len, count, inject, done_cyc, tx_pkts);
        tick();
        check("back_idle_done", done, 1'b0);
    endtask

    // Single packet, tready high, inspect one beat from the table
    task automatic apply_vec(input vec_t v);
        logic [7:0] dst;
        bit         seen;
        dst       = 8'($urandom);
        pkt_len   = 16'(v.len);
        pkt_count = 16'd1;
        dst_port  = dst;
        tready    = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < v.beat; b++) tick();
        check("vec_tvalid", tvalid, 1'b1);
        check("vec_tdata", tdata, v.data);
        check("vec_tstrb", tstrb, v.strb);
        check("vec_tlast", tlast, v.last);
        check("vec_tuser", tuser, user_of(v.len, dst));
        $display("vec len=%0d beat=%0d tdata=%08h tstrb=%h tlast=%0d",
                 v.len, v.beat, tdata, tstrb, tlast);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("vec_done_seen", seen, 1'b1);
        exp_tx = exp_tx + 32'd1;
        tick();
    endtask

    initial begin
        vt[0] = '{8,   0,  32'h03020100, 4'hF, 1'b0};
        vt[1] = '{8,   1,  32'h07060504, 4'hF, 1'b1};
        vt[2] = '{5,   0,  32'h03020100, 4'hF, 1'b0};
        vt[3] = '{5,   1,  32'h00000004, 4'h1, 1'b1};
        vt[4] = '{12,  2,  32'h0B0A0908, 4'hF, 1'b1};
        vt[5] = '{3,   0,  32'h00020100, 4'h7, 1'b1};
        vt[6] = '{6,   1,  32'h00000504, 4'h3, 1'b1};
        vt[7] = '{7,   1,  32'h00060504, 4'h7, 1'b1};
        vt[8] = '{300, 64, 32'h03020100, 4'hF, 1'b0};
        vt[9] = '{300, 74, 32'h2B2A2928, 4'hF, 1'b1};

        reset = 1'b1; start = 1'b0; pkt_len = '0; pkt_count = '0;
        dst_port = '0; tready = 1'b1;
        tick(); tick();
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx_pkts", tx_pkts, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tstrb", tstrb, 4'd0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tuser", tuser, 128'd0);
        reset = 1'b0;
        tick();

        // Basic packet, cycle-exact
        pkt_len = 16'd8; pkt_count = 16'd1; dst_port = 8'hA5; start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_c1_valid", tvalid, 1'b1);
        check("basic_c1_busy", busy, 1'b1);
        check("basic_c1_data", tdata, 32'h03020100);
        check("basic_c1_last", tlast, 1'b0);
        check("basic_c1_user", tuser, user_of(8, 8'hA5));
        tick();
        check("basic_c2_data", tdata, 32'h07060504);
        check("basic_c2_last", tlast, 1'b1);
        check("basic_c2_user", tuser, user_of(8, 8'hA5));
        tick();
        check("basic_c3_done", done, 1'b1);
        check("basic_c3_busy", busy, 1'b0);
        check("basic_c3_tx", tx_pkts, 32'd1);
        exp_tx = 32'd1;
        $display("basic tx_pkts=%0d done=%0d", tx_pkts, done);
        tick();

        // Backpressure: tready low in cycles 2-4
        pkt_len = 16'd12; pkt_count = 16'd1; dst_port = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        check("bp_c1_data", tdata, 32'h03020100);
        for (int c = 2; c <= 5; c++) begin
            tick();
            tready = (c == 5);
            check("bp_hold_valid", tvalid, 1'b1);
            check("bp_hold_data", tdata, 32'h07060504);
            check("bp_hold_last", tlast, 1'b0);
        end
        tick();
        tready = 1'b1;
        check("bp_c6_data", tdata, 32'h0B0A0908);
        check("bp_c6_last", tlast, 1'b1);
        tick();
        check("bp_done", done, 1'b1);
        exp_tx = exp_tx + 32'd1;
        $display("backpressure tx_pkts=%0d", tx_pkts);
        tick();

        // Back-to-back single-beat packets
        pkt_len = 16'd4; pkt_count = 16'd3; dst_port = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            check("b2b_valid", tvalid, 1'b1);
            check("b2b_data", tdata, 32'h03020100);
            check("b2b_last", tlast, 1'b1);
            tick();
        end
        exp_tx = exp_tx + 32'd3;
        check("b2b_done", done, 1'b1);
        check("b2b_tx", tx_pkts, exp_tx);
        $display("back_to_back tx_pkts=%0d", tx_pkts);
        tick();

        // Table vectors
        for (int i = 0; i < 10; i++) apply_vec(vt[i]);

        // Degenerate starts and start-while-busy
        run_pkts(0, 5, 8'h22, 1'b0);
        run_pkts(5, 0, 8'h23, 1'b0);
        run_pkts(8, 2, 8'h44, 1'b1);

        // Randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            run_pkts(int'($urandom_range(1, 70)), int'($urandom_range(1, 4)),
                     8'($urandom), 1'b0);
        end

        // Reset mid-packet, then fresh start
        pkt_len = 16'd20; pkt_count = 16'd1; dst_port = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_tx = 32'd0;
        check("midrst_tvalid", tvalid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_tx", tx_pkts, 32'd0);
        $display("mid_reset tvalid=%0d busy=%0d tx_pkts=%0d", tvalid, busy, tx_pkts);
        run_pkts(8, 1, 8'h5A, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
